// File: rtl/battleship_game.sv
// battleship_game
// Single-player battleship referee. Ships are loaded cell by cell in LOAD,
// shots are scored in PLAY with a registered one-cycle result strobe, and the
// game parks in OVER once every placed ship has been sunk.
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   LoadValid/LoadShip/LoadX/LoadY   write one ship cell (LOAD only)
//   Start                  end placement, enter PLAY if anything was placed
//   NewGame                clear board/counters and return to LOAD
//   ShotValid/ShotReady/X/Y          shot handshake and coordinates
//   ResultValid            one-cycle strobe, one cycle after an accepted shot
//   Hit/NearMiss/Miss/Repeat/Invalid one-hot result class
//   Sunk/SunkShip          this shot sank ship SunkShip
//   SunkMask               sticky per-ship sunk flags
//   NumHits/ShotsTaken     hit count, scored-shot count (saturating)
//   GameOver               high while in OVER
//   SomethingIsWrong       sticky placement error (cleared only by reset)
module battleship_game #(
    parameter int GRID      = 10,
    parameter int NUM_SHIPS = 5,
    localparam int SID_W    = (NUM_SHIPS > 1) ? $clog2(NUM_SHIPS) : 1,
    localparam int CW       = $clog2(GRID),
    localparam int HW       = $clog2(GRID*GRID+1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 LoadValid,
    input  logic [SID_W-1:0]     LoadShip,
    input  logic [CW-1:0]        LoadX,
    input  logic [CW-1:0]        LoadY,
    input  logic                 Start,
    input  logic                 NewGame,
    input  logic                 ShotValid,
    output logic                 ShotReady,
    input  logic [CW-1:0]        X,
    input  logic [CW-1:0]        Y,
    output logic                 ResultValid,
    output logic                 Hit,
    output logic                 NearMiss,
    output logic                 Miss,
    output logic                 Repeat,
    output logic                 Invalid,
    output logic                 Sunk,
    output logic [SID_W-1:0]     SunkShip,
    output logic [NUM_SHIPS-1:0] SunkMask,
    output logic [HW-1:0]        NumHits,
    output logic [HW-1:0]        ShotsTaken,
    output logic                 GameOver,
    output logic                 SomethingIsWrong
);

    localparam int NCELL = GRID*GRID;
    localparam int IW    = $clog2(NCELL);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    logic [1:0]           r_state;
    logic [NCELL-1:0]     r_occ;
    logic [NCELL-1:0]     r_shot;
    logic [SID_W-1:0]     r_sid  [NCELL];
    logic [HW-1:0]        r_len  [NUM_SHIPS];
    logic [HW-1:0]        r_hcnt [NUM_SHIPS];
    logic [NUM_SHIPS-1:0] r_sunk_mask;
    logic [HW-1:0]        r_num_hits;
    logic [HW-1:0]        r_shots;
    logic                 r_err;

    logic                 r_rvalid, r_hit, r_near, r_miss, r_rep, r_inv, r_sunk;
    logic [SID_W-1:0]     r_sunk_id;

    // ---------------- load decode ----------------
    logic          w_load_inr, w_load_sid_ok, w_load_cell_free;
    logic          w_load_legal, w_load_bad;
    logic [IW-1:0] w_load_idx;

    assign w_load_inr       = (int'(LoadX) < GRID) && (int'(LoadY) < GRID);
    assign w_load_sid_ok    = int'(LoadShip) < NUM_SHIPS;
    assign w_load_idx       = IW'(LoadY) * IW'(GRID) + IW'(LoadX);
    assign w_load_cell_free = w_load_inr && !r_occ[w_load_idx];
    assign w_load_legal     = LoadValid && (r_state == S_LOAD) && w_load_sid_ok && w_load_cell_free;
    assign w_load_bad       = LoadValid && (r_state == S_LOAD) && !(w_load_sid_ok && w_load_cell_free);

    // ---------------- shot decode ----------------
    logic          w_accept, w_shot_inr, w_nbr_occ;
    logic          w_c_inv, w_c_rep, w_c_hit, w_c_near, w_c_miss, w_scored;
    logic          w_x_lo, w_x_hi, w_y_lo, w_y_hi;
    logic [IW-1:0] w_shot_idx;
    logic [SID_W-1:0] w_hit_sid;
    logic          w_sinks, w_all_sunk;
    logic [NUM_SHIPS-1:0] w_new_mask;

    assign ShotReady  = (r_state == S_PLAY) && !NewGame;
    assign w_accept   = ShotValid && ShotReady;

    assign w_shot_inr = (int'(X) < GRID) && (int'(Y) < GRID);
    assign w_shot_idx = IW'(Y) * IW'(GRID) + IW'(X);

    // Edge guards keep neighbour lookups inside the grid; without them the
    // linear index would wrap from one row end into the next row.
    assign w_x_lo = (X != '0);
    assign w_x_hi = (int'(X) + 1) < GRID;
    assign w_y_lo = (Y != '0);
    assign w_y_hi = (int'(Y) + 1) < GRID;
    assign w_nbr_occ = (w_x_lo && r_occ[w_shot_idx - IW'(1)])
                    || (w_x_hi && r_occ[w_shot_idx + IW'(1)])
                    || (w_y_lo && r_occ[w_shot_idx - IW'(GRID)])
                    || (w_y_hi && r_occ[w_shot_idx + IW'(GRID)]);

    assign w_c_inv  = !w_shot_inr;
    assign w_c_rep  = w_shot_inr && r_shot[w_shot_idx];
    assign w_c_hit  = w_shot_inr && !r_shot[w_shot_idx] && r_occ[w_shot_idx];
    assign w_c_near = w_shot_inr && !r_shot[w_shot_idx] && !r_occ[w_shot_idx] && w_nbr_occ;
    assign w_c_miss = w_shot_inr && !r_shot[w_shot_idx] && !r_occ[w_shot_idx] && !w_nbr_occ;
    assign w_scored = w_c_hit || w_c_near || w_c_miss;

    assign w_hit_sid  = r_sid[w_shot_idx];
    assign w_sinks    = w_c_hit && ((r_hcnt[w_hit_sid] + HW'(1)) == r_len[w_hit_sid]);
    assign w_new_mask = r_sunk_mask | (w_sinks ? (NUM_SHIPS'(1) << w_hit_sid) : '0);

    // Only ships that were actually placed need to be sunk to end the game.
    always_comb begin
        w_all_sunk = 1'b1;
        for (int s = 0; s < NUM_SHIPS; s++) begin
            if ((r_len[s] != '0) && !w_new_mask[s]) w_all_sunk = 1'b0;
        end
    end

    // ---------------- board / FSM ----------------
    always_ff @(posedge clock) begin
        if (reset || NewGame) begin
            r_state     <= S_LOAD;
            r_occ       <= '0;
            r_shot      <= '0;
            r_sunk_mask <= '0;
            r_num_hits  <= '0;
            r_shots     <= '0;
            for (int i = 0; i < NCELL; i++)     r_sid[i]  <= '0;
            for (int s = 0; s < NUM_SHIPS; s++) begin
                r_len[s]  <= '0;
                r_hcnt[s] <= '0;
            end
            // NewGame keeps the sticky error; only reset clears it.
            if (reset) r_err <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_load_legal) begin
                        r_occ[w_load_idx]   <= 1'b1;
                        r_sid[w_load_idx]   <= LoadShip;
                        r_len[LoadShip]     <= r_len[LoadShip] + HW'(1);
                    end
                    if (w_load_bad) r_err <= 1'b1;
                    // A same-cycle legal load counts toward "board not empty".
                    if (Start) begin
                        if ((|r_occ) || w_load_legal) r_state <= S_PLAY;
                        else                          r_err   <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (w_accept && w_scored) begin
                        r_shot[w_shot_idx] <= 1'b1;
                        if (r_shots != '1) r_shots <= r_shots + HW'(1);
                        if (w_c_hit) begin
                            r_num_hits         <= r_num_hits + HW'(1);
                            r_hcnt[w_hit_sid]  <= r_hcnt[w_hit_sid] + HW'(1);
                            r_sunk_mask        <= w_new_mask;
                            if (w_sinks && w_all_sunk) r_state <= S_OVER;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- result strobe ----------------
    // Every result field is rewritten each cycle, so they read as zero
    // whenever no shot was accepted on the previous edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rvalid  <= 1'b0;
            r_hit     <= 1'b0;
            r_near    <= 1'b0;
            r_miss    <= 1'b0;
            r_rep     <= 1'b0;
            r_inv     <= 1'b0;
            r_sunk    <= 1'b0;
            r_sunk_id <= '0;
        end else begin
            r_rvalid  <= w_accept;
            r_hit     <= w_accept && w_c_hit;
            r_near    <= w_accept && w_c_near;
            r_miss    <= w_accept && w_c_miss;
            r_rep     <= w_accept && w_c_rep;
            r_inv     <= w_accept && w_c_inv;
            r_sunk    <= w_accept && w_sinks;
            r_sunk_id <= (w_accept && w_sinks) ? w_hit_sid : '0;
        end
    end

    assign ResultValid      = r_rvalid;
    assign Hit              = r_hit;
    assign NearMiss         = r_near;
    assign Miss             = r_miss;
    assign Repeat           = r_rep;
    assign Invalid          = r_inv;
    assign Sunk             = r_sunk;
    assign SunkShip         = r_sunk_id;
    assign SunkMask         = r_sunk_mask;
    assign NumHits          = r_num_hits;
    assign ShotsTaken       = r_shots;
    assign GameOver         = (r_state == S_OVER);
    assign SomethingIsWrong = r_err;

endmodule

// File: tb/tb_battleship_game.sv
// Directed bench for battleship_game at GRID=10, NUM_SHIPS=5.
module tb_battleship_game;

    logic       clock = 1'b0;
    logic       reset;
    logic       LoadValid;
    logic [2:0] LoadShip;
    logic [3:0] LoadX, LoadY;
    logic       Start, NewGame, ShotValid, ShotReady;
    logic [3:0] X, Y;
    logic       ResultValid, Hit, NearMiss, Miss, Repeat, Invalid, Sunk;
    logic [2:0] SunkShip;
    logic [4:0] SunkMask;
    logic [6:0] NumHits, ShotsTaken;
    logic       GameOver, SomethingIsWrong;

    int checks = 0;
    int errors = 0;

    battleship_game #(.GRID(10), .NUM_SHIPS(5)) dut (
        .clock(clock), .reset(reset),
        .LoadValid(LoadValid), .LoadShip(LoadShip), .LoadX(LoadX), .LoadY(LoadY),
        .Start(Start), .NewGame(NewGame),
        .ShotValid(ShotValid), .ShotReady(ShotReady), .X(X), .Y(Y),
        .ResultValid(ResultValid), .Hit(Hit), .NearMiss(NearMiss), .Miss(Miss),
        .Repeat(Repeat), .Invalid(Invalid), .Sunk(Sunk), .SunkShip(SunkShip),
        .SunkMask(SunkMask), .NumHits(NumHits), .ShotsTaken(ShotsTaken),
        .GameOver(GameOver), .SomethingIsWrong(SomethingIsWrong)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int s, input int lx, input int ly);
        LoadValid = 1'b1;
        LoadShip  = 3'(s);
        LoadX     = 4'(lx);
        LoadY     = 4'(ly);
        tick();
        LoadValid = 1'b0;
    endtask

    task automatic shoot(input int sx, input int sy);
        ShotValid = 1'b1;
        X         = 4'(sx);
        Y         = 4'(sy);
        tick();
        ShotValid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; LoadValid = 1'b0; LoadShip = '0; LoadX = '0; LoadY = '0;
        Start = 1'b0; NewGame = 1'b0; ShotValid = 1'b0; X = '0; Y = '0;
        tick(); tick();
        reset = 1'b0;

        // reset state
        chk("rst_ready",  ShotReady, 0);
        chk("rst_rvalid", ResultValid, 0);
        chk("rst_over",   GameOver, 0);
        chk("rst_err",    SomethingIsWrong, 0);
        chk("rst_hits",   NumHits, 0);

        // Start on an empty board: stay in LOAD, flag error
        Start = 1'b1; tick(); Start = 1'b0;
        chk("empty_start_ready", ShotReady, 0);
        chk("empty_start_err",   SomethingIsWrong, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("err_cleared", SomethingIsWrong, 0);

        // ship 0 at (2,3),(2,4)
        load(0, 2, 3); load(0, 2, 4);
        Start = 1'b1; tick(); Start = 1'b0;
        chk("play_ready", ShotReady, 1);
        chk("play_err",   SomethingIsWrong, 0);

        shoot(3, 3);
        chk("near_rv",   ResultValid, 1);
        chk("near",      NearMiss, 1);
        chk("near_hit",  Hit, 0);
        chk("near_shots", ShotsTaken, 1);
        shoot(9, 9);
        chk("miss",       Miss, 1);
        chk("miss_shots", ShotsTaken, 2);
        shoot(9, 9);
        chk("repeat",       Repeat, 1);
        chk("repeat_miss",  Miss, 0);
        chk("repeat_shots", ShotsTaken, 2);
        tick();
        chk("idle_rv",  ResultValid, 0);
        chk("idle_rep", Repeat, 0);

        shoot(2, 3);
        chk("hit1",       Hit, 1);
        chk("hit1_sunk",  Sunk, 0);
        chk("hit1_nhits", NumHits, 1);
        chk("hit1_over",  GameOver, 0);
        shoot(2, 4);
        chk("hit2",       Hit, 1);
        chk("hit2_sunk",  Sunk, 1);
        chk("hit2_sid",   SunkShip, 0);
        chk("hit2_mask",  SunkMask, 1);
        chk("hit2_over",  GameOver, 1);
        chk("hit2_ready", ShotReady, 0);
        chk("hit2_nhits", NumHits, 2);
        chk("hit2_shots", ShotsTaken, 4);

        // NewGame with a shot in OVER
        NewGame = 1'b1; ShotValid = 1'b1; X = 4'd5; Y = 4'd5;
        #1;
        chk("ng_ready_comb", ShotReady, 0);
        tick();
        NewGame = 1'b0; ShotValid = 1'b0;
        chk("ng_rv",    ResultValid, 0);
        chk("ng_over",  GameOver, 0);
        chk("ng_mask",  SunkMask, 0);
        chk("ng_hits",  NumHits, 0);
        chk("ng_shots", ShotsTaken, 0);
        chk("ng_ready", ShotReady, 0);

        // Load and Start in the same cycle; corner ship at (0,0)
        LoadValid = 1'b1; LoadShip = 3'd0; LoadX = 4'd0; LoadY = 4'd0; Start = 1'b1;
        tick();
        LoadValid = 1'b0; Start = 1'b0;
        chk("ldstart_ready", ShotReady, 1);
        chk("ldstart_err",   SomethingIsWrong, 0);
        shoot(0, 1);
        chk("corner_near", NearMiss, 1);
        shoot(9, 0);
        chk("nowrap_miss",  Miss, 1);
        chk("nowrap_near",  NearMiss, 0);
        chk("nowrap_shots", ShotsTaken, 2);
        shoot(10, 2);
        chk("inv",       Invalid, 1);
        chk("inv_miss",  Miss, 0);
        chk("inv_shots", ShotsTaken, 2);
        chk("inv_hits",  NumHits, 0);

        // duplicate load keeps length 1
        reset = 1'b1; tick(); reset = 1'b0;
        load(2, 4, 4); load(2, 4, 4);
        chk("dup_err", SomethingIsWrong, 1);
        load(3, 7, 7);
        Start = 1'b1; tick(); Start = 1'b0;
        chk("dup_ready", ShotReady, 1);
        shoot(4, 4);
        chk("dup_hit",  Hit, 1);
        chk("dup_sunk", Sunk, 1);
        chk("dup_sid",  SunkShip, 2);
        chk("dup_mask", SunkMask, 4);
        chk("dup_over", GameOver, 0);

        // ShotValid held for three cycles
        ShotValid = 1'b1; X = 4'd0; Y = 4'd0;
        tick(); chk("bb_rv0", ResultValid, 1); chk("bb_miss0", Miss, 1);
        X = 4'd1;
        tick(); chk("bb_rv1", ResultValid, 1);
        X = 4'd2;
        tick(); chk("bb_rv2", ResultValid, 1);
        ShotValid = 1'b0;
        chk("bb_shots", ShotsTaken, 4);
        tick(); chk("bb_rv_end", ResultValid, 0);

        // reset during the second of a burst
        ShotValid = 1'b1; X = 4'd3; Y = 4'd0;
        tick();
        chk("rb_rv0",    ResultValid, 1);
        chk("rb_shots0", ShotsTaken, 5);
        reset = 1'b1; X = 4'd4;
        tick();
        reset = 1'b0; ShotValid = 1'b0;
        chk("rb_rv",    ResultValid, 0);
        chk("rb_miss",  Miss, 0);
        chk("rb_hits",  NumHits, 0);
        chk("rb_shots", ShotsTaken, 0);
        chk("rb_mask",  SunkMask, 0);
        chk("rb_err",   SomethingIsWrong, 0);
        chk("rb_ready", ShotReady, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
